demoscene_vga_out: RTL and testbench

- Parametrised VGA output stage for the demoscene datapath; generalises the fixed 2-bit-per-channel, fixed-640x480 output pinout.
- Generates H/V timing, exposes pixel coordinates to the renderer, and takes renderer colour at COLOR_W bits per channel.
- Reduces colour to OUT_W bits per channel, blanks outside the active area, and registers RGB and syncs together so they stay aligned at the pads.
- Sits between the renderer and the top-level uo_out mapping.

---
 rtl/demoscene_vga_out.sv | 152 +++++++++++++++
 tb/tb_demoscene_vga_out.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/demoscene_vga_out.sv
// VGA output stage: H/V timing, colour reduction, blanking and registered pins.
// Optional 2x2 ordered dither on colour reduction under DEMOSCENE_VGA_DITHER_EN.
module demoscene_vga_out #(
  parameter int unsigned COLOR_W  = 4,
  parameter int unsigned OUT_W    = 2,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0,
  parameter int unsigned CNT_W    = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pix_ce,
  input  logic [3*COLOR_W-1:0]   rgb_in,
  output logic [CNT_W-1:0]       pix_x,
  output logic [CNT_W-1:0]       pix_y,
  output logic                   active,
  output logic                   line_start,
  output logic                   frame_start,
  output logic [OUT_W-1:0]       vga_r,
  output logic [OUT_W-1:0]       vga_g,
  output logic [OUT_W-1:0]       vga_b,
  output logic                   hsync,
  output logic                   vsync
);

  localparam int unsigned HTotal  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HsStart = H_ACTIVE + H_FP;
  localparam int unsigned HsEnd   = H_ACTIVE + H_FP + H_SYNC;
  localparam int unsigned VsStart = V_ACTIVE + V_FP;
  localparam int unsigned VsEnd   = V_ACTIVE + V_FP + V_SYNC;
  localparam int unsigned DropW   = COLOR_W - OUT_W;

  localparam logic [CNT_W-1:0] HLast = CNT_W'(HTotal - 1);
  localparam logic [CNT_W-1:0] VLast = CNT_W'(VTotal - 1);

  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
  logic [OUT_W-1:0] vga_r_q, vga_r_d;
  logic [OUT_W-1:0] vga_g_q, vga_g_d;
  logic [OUT_W-1:0] vga_b_q, vga_b_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;

  int unsigned      h_i, v_i;
  logic             hs_raw, vs_raw;
  logic [COLOR_W-1:0] ch_r, ch_g, ch_b;
  logic [OUT_W-1:0] red_r, red_g, red_b;

  assign h_i = 32'(h_cnt_q);
  assign v_i = 32'(v_cnt_q);

  assign ch_r = rgb_in[3*COLOR_W-1 -: COLOR_W];
  assign ch_g = rgb_in[2*COLOR_W-1 -: COLOR_W];
  assign ch_b = rgb_in[COLOR_W-1:0];

  assign active = (h_i < H_ACTIVE) && (v_i < V_ACTIVE);
  assign hs_raw = (h_i >= HsStart) && (h_i < HsEnd);
  assign vs_raw = (v_i >= VsStart) && (v_i < VsEnd);

`ifdef DEMOSCENE_VGA_DITHER_EN
  // Bayer threshold is scaled so it spans one LSB of the reduced output.
  localparam int unsigned DShl = (DropW >= 2) ? DropW - 2 : 0;
  localparam int unsigned DShr = (DropW >= 2) ? 0 : 2 - DropW;
  localparam int unsigned MaxC = (2 ** COLOR_W) - 1;

  logic [1:0] bayer;

  always_comb begin
    case ({v_cnt_q[0], h_cnt_q[0]})
      2'b00:   bayer = 2'd0;
      2'b01:   bayer = 2'd2;
      2'b10:   bayer = 2'd3;
      default: bayer = 2'd1;
    endcase
  end

  function automatic logic [OUT_W-1:0] dither(input logic [COLOR_W-1:0] ch,
                                              input logic [1:0]         b);
    int unsigned t;
    int unsigned s;
    t = (32'(b) << DShl) >> DShr;
    s = 32'(ch) + t;
    if (s > MaxC) s = MaxC;
    return OUT_W'(s >> DropW);
  endfunction

  assign red_r = dither(ch_r, bayer);
  assign red_g = dither(ch_g, bayer);
  assign red_b = dither(ch_b, bayer);
`else
  assign red_r = OUT_W'(ch_r >> DropW);
  assign red_g = OUT_W'(ch_g >> DropW);
  assign red_b = OUT_W'(ch_b >> DropW);
`endif

  always_comb begin
    h_cnt_d = h_cnt_q + CNT_W'(1);
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == HLast) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == VLast) ? '0 : v_cnt_q + CNT_W'(1);
    end
  end

  // RGB and syncs share one register stage so they reach the pads aligned.
  always_comb begin
    vga_r_d = active ? red_r : '0;
    vga_g_d = active ? red_g : '0;
    vga_b_d = active ? red_b : '0;
    hsync_d = hs_raw ? SYNC_POL : ~SYNC_POL;
    vsync_d = vs_raw ? SYNC_POL : ~SYNC_POL;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      vga_r_q <= '0;
      vga_g_q <= '0;
      vga_b_q <= '0;
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
    end else if (pix_ce) begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      vga_r_q <= vga_r_d;
      vga_g_q <= vga_g_d;
      vga_b_q <= vga_b_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

  assign pix_x       = h_cnt_q;
  assign pix_y       = v_cnt_q;
  assign line_start  = pix_ce && (h_cnt_q == '0);
  assign frame_start = line_start && (v_cnt_q == '0);
  assign vga_r       = vga_r_q;
  assign vga_g       = vga_g_q;
  assign vga_b       = vga_b_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;

endmodule

// File: tb/tb_demoscene_vga_out.sv
// Bench for demoscene_vga_out: default 640x480 instance plus a tiny-timing instance,
// both checked every cycle against a pixel-index model of the raster.
module tb_demoscene_vga_out;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pix_ce = 1'b0;
  logic [11:0] rgb_in = '0;

  logic [9:0] d_pix_x, d_pix_y;
  logic       d_active, d_ls, d_fs, d_hs, d_vs;
  logic [1:0] d_r, d_g, d_b;
  logic [3:0] s_pix_x, s_pix_y;
  logic       s_active, s_ls, s_fs, s_hs, s_vs;
  logic [1:0] s_r, s_g, s_b;

  int checks = 0;
  int passes = 0;

  // Per-instance timing: index 0 = defaults, index 1 = tiny raster.
  int HA[2] = '{640, 8};
  int HF[2] = '{16, 1};
  int HS[2] = '{96, 2};
  int HB[2] = '{48, 1};
  int VA[2] = '{480, 4};
  int VF[2] = '{10, 1};
  int VS[2] = '{2, 1};
  int VB[2] = '{33, 1};
  int POL[2] = '{0, 1};

  int n[2];
  int er[2][3];
  int ehs[2], evs[2];

`ifdef DEMOSCENE_VGA_DITHER_EN
  localparam int ExpR01 = 2;
`else
  localparam int ExpR01 = 1;
`endif

  always #5 clk = ~clk;

  demoscene_vga_out u_dflt (
    .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce), .rgb_in(rgb_in),
    .pix_x(d_pix_x), .pix_y(d_pix_y), .active(d_active),
    .line_start(d_ls), .frame_start(d_fs),
    .vga_r(d_r), .vga_g(d_g), .vga_b(d_b), .hsync(d_hs), .vsync(d_vs)
  );

  demoscene_vga_out #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b1), .CNT_W(4)
  ) u_small (
    .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce), .rgb_in(rgb_in),
    .pix_x(s_pix_x), .pix_y(s_pix_y), .active(s_active),
    .line_start(s_ls), .frame_start(s_fs),
    .vga_r(s_r), .vga_g(s_g), .vga_b(s_b), .hsync(s_hs), .vsync(s_vs)
  );

  function automatic int htot(int k);
    return HA[k] + HF[k] + HS[k] + HB[k];
  endfunction

  function automatic int vtot(int k);
    return VA[k] + VF[k] + VS[k] + VB[k];
  endfunction

  // 4-bit channel to 2 output bits; dither adds a Bayer threshold first.
  function automatic int reduce4(int chan, int h, int v);
`ifdef DEMOSCENE_VGA_DITHER_EN
    int bay[4] = '{0, 2, 3, 1};
    int s;
    s = chan + bay[(v % 2) * 2 + (h % 2)];
    if (s > 15) s = 15;
    return s / 4;
`else
    return chan / 4;
`endif
  endfunction

  task automatic chk(string nm, int k, int got, int exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s dut%0d t=%0t got %0d expected %0d", nm, k, $time, got, exp);
  endtask

  task automatic cmp(int k, int px, int py, int ac, int ls, int fs,
                     int r, int g, int b, int hs, int vs);
    int h, v;
    h = n[k] % htot(k);
    v = (n[k] / htot(k)) % vtot(k);
    chk("pix_x", k, px, h);
    chk("pix_y", k, py, v);
    chk("active", k, ac, int'(h < HA[k] && v < VA[k]));
    chk("line_start", k, ls, int'(pix_ce && h == 0));
    chk("frame_start", k, fs, int'(pix_ce && h == 0 && v == 0));
    chk("vga_r", k, r, er[k][0]);
    chk("vga_g", k, g, er[k][1]);
    chk("vga_b", k, b, er[k][2]);
    chk("hsync", k, hs, ehs[k]);
    chk("vsync", k, vs, evs[k]);
  endtask

  task automatic upd(int k, bit ce, logic [11:0] rgb, bit rst);
    int h, v, hs0, vs0;
    bit a;
    if (!rst) begin
      n[k] = 0;
      for (int c = 0; c < 3; c++) er[k][c] = 0;
      ehs[k] = 1 - POL[k];
      evs[k] = 1 - POL[k];
    end else if (ce) begin
      h = n[k] % htot(k);
      v = (n[k] / htot(k)) % vtot(k);
      a = (h < HA[k]) && (v < VA[k]);
      for (int c = 0; c < 3; c++)
        er[k][c] = a ? reduce4((int'(rgb) >> (8 - 4 * c)) & 15, h, v) : 0;
      hs0 = HA[k] + HF[k];
      vs0 = VA[k] + VF[k];
      ehs[k] = (h >= hs0 && h < hs0 + HS[k]) ? POL[k] : 1 - POL[k];
      evs[k] = (v >= vs0 && v < vs0 + VS[k]) ? POL[k] : 1 - POL[k];
      n[k]++;
    end
  endtask

  // Called just after a posedge; returns just after the next posedge.
  task automatic step(bit ce, logic [11:0] rgb, bit rst);
    pix_ce = ce;
    rgb_in = rgb;
    rst_n  = rst;
    @(negedge clk);
    cmp(0, int'(d_pix_x), int'(d_pix_y), int'(d_active), int'(d_ls), int'(d_fs),
        int'(d_r), int'(d_g), int'(d_b), int'(d_hs), int'(d_vs));
    cmp(1, int'(s_pix_x), int'(s_pix_y), int'(s_active), int'(s_ls), int'(s_fs),
        int'(s_r), int'(s_g), int'(s_b), int'(s_hs), int'(s_vs));
    @(posedge clk);
    upd(0, ce, rgb, rst);
    upd(1, ce, rgb, rst);
    #1;
  endtask

  initial begin
    int acnt;
    int steps;
    logic [11:0] rgb;
    acnt = 0;
    upd(0, 1'b0, 12'h000, 1'b0);
    upd(1, 1'b0, 12'h000, 1'b0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) step(1'b0, 12'h000, 1'b0);
    chk("rst_hsync_lit", 0, int'(d_hs), 1);
    chk("rst_hsync_lit", 1, int'(s_hs), 0);
    chk("rst_vga_r_lit", 0, int'(d_r), 0);
    pix_ce = 1'b1;
    rst_n  = 1'b1;
    #1;
    chk("first_frame_start_lit", 0, int'(d_fs), 1);

    // Continuous pixel clock: fixed colour first, then random.
    for (int i = 0; i < 1700; i++) begin
      if (i < 84) acnt += int'(s_active);
      rgb = (i < 14) ? 12'h5F5 : 12'($urandom);
      step(1'b1, rgb, 1'b1);
      steps = i + 1;
      if (steps == 1) begin
        chk("px00_r_lit", 0, int'(d_r), 1);
        chk("px00_g_lit", 0, int'(d_g), 3);
      end
      if (steps == 2) chk("px10_r_lit", 0, int'(d_r), 1);
      if (steps == 12) begin
        chk("line1_start_lit", 1, int'(s_ls), 1);
        chk("line1_y_lit", 1, int'(s_pix_y), 1);
      end
      if (steps == 13) begin
        chk("px01_r_lit", 1, int'(s_r), ExpR01);
        chk("px01_g_sat_lit", 1, int'(s_g), 3);
      end
      if (steps == 84) begin
        chk("active_per_frame_lit", 1, acnt, 32);
        chk("frame_wrap_lit", 1, int'(s_fs), 1);
      end
      if (steps == 656) chk("hsync_656_lit", 0, int'(d_hs), 1);
      if (steps == 657) chk("hsync_657_lit", 0, int'(d_hs), 0);
      if (steps == 752) chk("hsync_752_lit", 0, int'(d_hs), 0);
      if (steps == 753) chk("hsync_753_lit", 0, int'(d_hs), 1);
      if (steps == 800) chk("line_period_lit", 0, int'(d_pix_x), 0);
    end

    // Random enable with occasional reset.
    for (int i = 0; i < 3000; i++)
      step(1'($urandom_range(0, 1)), 12'($urandom), ($urandom_range(0, 299) != 0));

    // Every-other-clock enable.
    for (int i = 0; i < 400; i++) step(1'(i % 2), 12'($urandom), 1'b1);

    // Mid-frame reset with enable low still forces reset values.
    step(1'b0, 12'hFFF, 1'b0);
    chk("midrst_x_lit", 0, int'(d_pix_x), 0);
    chk("midrst_y_lit", 1, int'(s_pix_y), 0);
    chk("midrst_r_lit", 0, int'(d_r), 0);
    chk("midrst_hs_lit", 0, int'(d_hs), 1);
    pix_ce = 1'b1;
    rst_n  = 1'b1;
    #1;
    chk("midrst_fs_lit", 0, int'(d_fs), 1);
    for (int i = 0; i < 200; i++) step(1'b1, 12'($urandom), 1'b1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
